bp_be_perf_stat_tx: RTL and testbench

BP_BE_PERF_STAT_TX -- requirements
Module: bp_be_perf_stat_tx

---
 rtl/bp_be_pkg.sv | 30 +++
 rtl/bp_be_perf_counter.sv | 21 ++
 rtl/bp_be_perf_stat_tx.sv | 146 ++++++++++++++
 tb/tb_bp_be_perf_stat_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend performance-stat transmitter.
// Macro BP_BE_PERF_STALL_CNT_EN adds the stall counter word and the e_stall state.
package bp_be_pkg;

  localparam logic [7:0] bp_be_perf_magic_gp = 8'hA5;

`ifdef BP_BE_PERF_STALL_CNT_EN
  localparam logic [7:0] bp_be_perf_word_cnt_gp = 8'd3;
`else
  localparam logic [7:0] bp_be_perf_word_cnt_gp = 8'd2;
`endif

  typedef enum logic [2:0] {
    e_idle  = 3'd0,
    e_hdr   = 3'd1,
    e_clk   = 3'd2,
    e_instr = 3'd3,
`ifdef BP_BE_PERF_STALL_CNT_EN
    e_stall = 3'd4,
`endif
    e_done  = 3'd5
  } bp_be_perf_tx_state_e;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  word_cnt;
    logic [47:0] hart_id;
  } bp_be_perf_hdr_s;

endpackage

// File: rtl/bp_be_perf_counter.sv
// 64-bit event counter: synchronous clear has priority, otherwise adds inc_i.
// Wraps modulo 2^64.
module bp_be_perf_counter (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [63:0] cnt_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_o + 64'(inc_i);
    end
  end

endmodule

// File: rtl/bp_be_perf_stat_tx.sv
// Counts cycles/retired instructions and, on finish, streams a header plus counter
// snapshots over valid/ready. Macro BP_BE_PERF_STALL_CNT_EN adds a stall-count word.
module bp_be_perf_stat_tx
  import bp_be_pkg::*;
#(
  parameter  int num_core_p = 1,
  localparam int hart_w     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 freeze_i,
  input  logic [hart_w-1:0]    mhartid_i,
  input  logic                 commit_v_i,
  input  logic                 finish_i,
  input  logic                 stall_i,
  output logic [63:0]          data_o,
  output logic                 v_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output bp_be_perf_tx_state_e debug_state_o
);

  // Handshake: a word moves on a rising edge where v_o && ready_i. v_o and data_o
  // are decoded from the state and snapshot registers only, so they never depend on
  // ready_i and stay stable until the word is taken.

  bp_be_perf_tx_state_e state_r, state_n;

  logic [63:0]       clk_cnt_r, instr_cnt_r;
  logic [63:0]       clk_snap_r, instr_snap_r;
  logic [hart_w-1:0] hart_snap_r;
  logic              snap_en;
  bp_be_perf_hdr_s   hdr;

  bp_be_perf_counter clk_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (freeze_i),
    .inc_i     (1'b1),
    .cnt_o     (clk_cnt_r)
  );

  bp_be_perf_counter instr_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (freeze_i),
    .inc_i     (commit_v_i),
    .cnt_o     (instr_cnt_r)
  );

  // Snapshots capture the pre-increment register values on the launching edge.
  assign snap_en = (state_r == e_idle) && finish_i && !freeze_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_snap_r   <= '0;
      instr_snap_r <= '0;
      hart_snap_r  <= '0;
    end else if (snap_en) begin
      clk_snap_r   <= clk_cnt_r;
      instr_snap_r <= instr_cnt_r;
      hart_snap_r  <= mhartid_i;
    end
  end

`ifdef BP_BE_PERF_STALL_CNT_EN
  logic [63:0] stall_cnt_r, stall_snap_r;

  bp_be_perf_counter stall_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (freeze_i),
    .inc_i     (stall_i),
    .cnt_o     (stall_cnt_r)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_snap_r <= '0;
    end else if (snap_en) begin
      stall_snap_r <= stall_cnt_r;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall_i;
`endif

  assign hdr.magic    = bp_be_perf_magic_gp;
  assign hdr.word_cnt = bp_be_perf_word_cnt_gp;
  assign hdr.hart_id  = 48'(hart_snap_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    v_o     = 1'b0;
    data_o  = '0;
    case (state_r)
      e_idle: begin
        if (finish_i && !freeze_i) state_n = e_hdr;
      end
      e_hdr: begin
        v_o    = 1'b1;
        data_o = hdr;
        if (ready_i) state_n = e_clk;
      end
      e_clk: begin
        v_o    = 1'b1;
        data_o = clk_snap_r;
        if (ready_i) state_n = e_instr;
      end
      e_instr: begin
        v_o    = 1'b1;
        data_o = instr_snap_r;
`ifdef BP_BE_PERF_STALL_CNT_EN
        if (ready_i) state_n = e_stall;
`else
        if (ready_i) state_n = e_done;
`endif
      end
`ifdef BP_BE_PERF_STALL_CNT_EN
      e_stall: begin
        v_o    = 1'b1;
        data_o = stall_snap_r;
        if (ready_i) state_n = e_done;
      end
`endif
      // Hold here until finish drops so a held-high finish yields a single report.
      e_done: begin
        if (!finish_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign busy_o        = (state_r != e_idle);
  assign debug_state_o = state_r;

endmodule

// File: tb/tb_bp_be_perf_stat_tx.sv
// Directed bench for bp_be_perf_stat_tx with a scoreboard of expected stat words.
// Builds with or without BP_BE_PERF_STALL_CNT_EN.
module tb_bp_be_perf_stat_tx;
  import bp_be_pkg::*;

`ifdef BP_BE_PERF_STALL_CNT_EN
  localparam logic [63:0] exp_hdr = 64'hA503_0000_0000_0000;
`else
  localparam logic [63:0] exp_hdr = 64'hA502_0000_0000_0000;
`endif

  logic                 clk_i      = 1'b0;
  logic                 reset_n_i  = 1'b0;
  logic                 freeze_i   = 1'b0;
  logic [0:0]           mhartid_i  = 1'b0;
  logic                 commit_v_i = 1'b0;
  logic                 finish_i   = 1'b0;
  logic                 stall_i    = 1'b0;
  logic                 ready_i    = 1'b0;
  logic [63:0]          data_o;
  logic                 v_o;
  logic                 busy_o;
  bp_be_perf_tx_state_e debug_state_o;

  logic [63:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // Reference counters following the counting rules, independent of the FSM.
  logic [63:0] m_clk, m_instr, m_stall;

  bp_be_perf_stat_tx #(.num_core_p(1)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .freeze_i      (freeze_i),
    .mhartid_i     (mhartid_i),
    .commit_v_i    (commit_v_i),
    .finish_i      (finish_i),
    .stall_i       (stall_i),
    .data_o        (data_o),
    .v_o           (v_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .debug_state_o (debug_state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_clk   <= '0;
      m_instr <= '0;
      m_stall <= '0;
    end else if (freeze_i) begin
      m_clk   <= '0;
      m_instr <= '0;
      m_stall <= '0;
    end else begin
      m_clk   <= m_clk + 64'd1;
      m_instr <= m_instr + 64'(commit_v_i);
      m_stall <= m_stall + 64'(stall_i);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called while idle with finish just raised: the next edge takes these snapshots.
  task automatic push_report();
    exp_q.push_back(exp_hdr);
    exp_q.push_back(m_clk);
    exp_q.push_back(m_instr);
`ifdef BP_BE_PERF_STALL_CNT_EN
    exp_q.push_back(m_stall);
`endif
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && v_o && ready_i) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_word observed=%h expected=none", data_o);
      end else begin
        check("word", data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  stall_pat;
  logic [63:0] s5_instr;

  initial begin
    // Reset state
    #3;
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_state", 64'(debug_state_o), 64'(e_idle));
    step();
    reset_n_i = 1'b1;

    // Scenario 1: 10 commit cycles, then finish with ready held high
    commit_v_i = 1'b1;
    repeat (10) step();
    commit_v_i = 1'b0;
    finish_i   = 1'b1;
    ready_i    = 1'b1;
    push_report();
    step();
    check("s1_hdr_v", 64'(v_o), 64'd1);
    check("s1_hdr", data_o, exp_hdr);
    step();
    check("s1_clk", data_o, 64'd10);
    step();
    check("s1_instr", data_o, 64'd10);
`ifdef BP_BE_PERF_STALL_CNT_EN
    step();
    check("s1_stall", data_o, 64'd0);
`endif
    step();
    check("s1_done_v", 64'(v_o), 64'd0);
    check("s1_done_state", 64'(debug_state_o), 64'(e_done));

    // Scenario 3a: finish held high gives no second report
    commit_v_i = 1'b1;
    repeat (5) step();
    check("s3_hold_v", 64'(v_o), 64'd0);
    check("s3_hold_busy", 64'(busy_o), 64'd1);

    // Scenario 3b + 2: finish low one cycle, then high with ready stalled
    finish_i = 1'b0;
    step();
    check("s3_idle", 64'(debug_state_o), 64'(e_idle));
    finish_i = 1'b1;
    ready_i  = 1'b0;
    push_report();
    step();
    for (int i = 0; i < 5; i++) begin
      check("s2_stall_v", 64'(v_o), 64'd1);
      check("s2_stall_data", data_o, exp_hdr);
      step();
    end
    ready_i = 1'b1;
`ifdef BP_BE_PERF_STALL_CNT_EN
    repeat (4) step();
`else
    repeat (3) step();
`endif
    check("s3_second_done_v", 64'(v_o), 64'd0);
    check("s3_queue_drained", 64'(exp_q.size()), 64'd0);

    // Scenario 4: reset after the clk word is accepted
    finish_i = 1'b0;
    step();
    finish_i = 1'b1;
    exp_q.push_back(exp_hdr);
    exp_q.push_back(m_clk);
    step();
    step();
    check("s4_clk_state", 64'(debug_state_o), 64'(e_clk));
    step();
    ready_i = 1'b0;
    #1;
    reset_n_i = 1'b0;
    #1;
    check("s4_rst_v", 64'(v_o), 64'd0);
    check("s4_rst_state", 64'(debug_state_o), 64'(e_idle));
    check("s4_rst_data", data_o, 64'd0);
    finish_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    ready_i   = 1'b1;
    repeat (3) step();
    check("s4_after_v", 64'(v_o), 64'd0);
    check("s4_after_busy", 64'(busy_o), 64'd0);
    check("s4_queue", 64'(exp_q.size()), 64'd0);

    // Scenario 5: clear, 8 cycles with 3 stall cycles, freeze pulse mid-report
    freeze_i = 1'b1;
    step();
    freeze_i  = 1'b0;
    stall_pat = 8'b1010_0100;
    for (int i = 0; i < 8; i++) begin
      commit_v_i = 1'($urandom_range(0, 1));
      stall_i    = stall_pat[i];
      step();
    end
    commit_v_i = 1'b0;
    stall_i    = 1'b0;
    finish_i   = 1'b1;
    s5_instr   = m_instr;
    push_report();
    step();
    check("s5_hdr", data_o, exp_hdr);
    freeze_i = 1'b1;
    step();
    check("s5_clk", data_o, 64'd8);
    step();
    check("s5_instr", data_o, s5_instr);
    freeze_i = 1'b0;
`ifdef BP_BE_PERF_STALL_CNT_EN
    step();
    check("s5_stall", data_o, 64'd3);
`endif
    step();
    check("s5_done_v", 64'(v_o), 64'd0);
    finish_i = 1'b0;
    step();
    check("s5_end_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
